// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the 8259-style INTA sequencer.
package pic_pkg;

  localparam int unsigned NUM_IR  = 8;
  localparam int unsigned LEVEL_W = 3;
  localparam int unsigned BASE_W  = 5;
  localparam int unsigned VEC_W   = BASE_W + LEVEL_W;
  localparam int unsigned CNT_W   = 8;

  // Level reported when the first INTA finds no eligible request.
  localparam logic [LEVEL_W-1:0] SPURIOUS_LVL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK1,
    ST_ACK2
  } pic_state_e;

  // Result of a priority search: lowest set index wins (IR0 highest).
  typedef struct packed {
    logic               valid;
    logic [LEVEL_W-1:0] level;
  } pic_sel_t;

  // Find-first-set from bit 0 upward.
  function automatic pic_sel_t find_first(input logic [NUM_IR-1:0] bits);
    pic_sel_t sel;
    sel = '0;
    for (int i = int'(NUM_IR) - 1; i >= 0; i--) begin
      if (bits[i]) begin
        sel.valid = 1'b1;
        sel.level = LEVEL_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pic_inta_sequencer_if.sv
// pic_inta_sequencer_if: CPU-side interrupt/acknowledge bus of the PIC.
interface pic_inta_sequencer_if;

  logic                     inta_n;
  logic                     int_out;
  logic [pic_pkg::VEC_W-1:0] vector_out;
  logic                     vector_oe;

  // CPU side drives the acknowledge strobe and receives request and vector.
  modport master (output inta_n, input int_out, input vector_out, input vector_oe);
  // PIC side.
  modport slave  (input inta_n, output int_out, output vector_out, output vector_oe);

endinterface

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: fully nested priority pick over pending requests,
// gated by the in-service register; also reports the top in-service level.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] req,
  input  logic [NUM_IR-1:0] isr,
  output pic_sel_t          win_c,
  output pic_sel_t          isr_top_c
);

  pic_sel_t req_sel;

  // A request wins only if strictly higher priority than every in-service level.
  always_comb begin
    req_sel   = find_first(req);
    isr_top_c = find_first(isr);
    win_c     = req_sel;
    if (isr_top_c.valid && (req_sel.level >= isr_top_c.level)) begin
      win_c.valid = 1'b0;
    end
  end

endmodule

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: IRR/ISR bookkeeping and the two-pulse INTA handshake.
// Optional auto-EOI (aeoi port) is built when PIC_AEOI_EN is defined.
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned INTA_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_done,
  input  logic                ltim,
  input  logic [BASE_W-1:0]   vec_base,
  input  logic [NUM_IR-1:0]   imr,
  input  logic [NUM_IR-1:0]   irq,
  input  logic                eoi_valid,
  input  logic                eoi_specific,
  input  logic [LEVEL_W-1:0]  eoi_level,
`ifdef PIC_AEOI_EN
  input  logic                aeoi,
`endif
  pic_inta_sequencer_if.slave bus,
  output logic [NUM_IR-1:0]   irr,
  output logic [NUM_IR-1:0]   isr
);

  pic_state_e          state_q, state_d;
  logic [NUM_IR-1:0]   irq_q, irr_q, irr_d, isr_q, isr_d;
  logic                inta_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEVEL_W-1:0]  lvl_q, lvl_d;
  logic                real_q, real_d;
  logic                int_out_q, int_out_d;
  logic                oe_q, oe_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic                inta_fall_c;
  pic_sel_t            win_c, isr_top_c;

  pic_priority_resolver u_resolver (
    .req       (irr_q & ~imr),
    .isr       (isr_q),
    .win_c     (win_c),
    .isr_top_c (isr_top_c)
  );

  assign inta_fall_c = inta_q & ~bus.inta_n;

  // Next-state, register updates and registered output values.
  always_comb begin
    state_d = state_q;
    irr_d   = ltim ? irq : (irr_q | (irq & ~irq_q));
    isr_d   = isr_q;
    cnt_d   = '0;
    lvl_d   = lvl_q;
    real_d  = real_q;

    if (!init_done) begin
      state_d = ST_IDLE;
      irr_d   = '0;
      isr_d   = '0;
    end else begin
      if (eoi_valid) begin
        if (eoi_specific) begin
          isr_d[eoi_level] = 1'b0;
        end else if (isr_top_c.valid) begin
          isr_d[isr_top_c.level] = 1'b0;
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (win_c.valid) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (inta_fall_c) begin
            state_d = ST_ACK1;
            real_d  = win_c.valid;
            lvl_d   = win_c.valid ? win_c.level : SPURIOUS_LVL;
            if (win_c.valid) begin
              isr_d[win_c.level] = 1'b1;
              irr_d[win_c.level] = 1'b0;
            end
          end else if (!win_c.valid) begin
            state_d = ST_IDLE;
          end
        end
        ST_ACK1: begin
          if (inta_fall_c) begin
            state_d = ST_ACK2;
          end else if (cnt_q == CNT_W'(INTA_TIMEOUT - 1)) begin
            state_d = ST_IDLE;
            if (real_q) isr_d[lvl_q] = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ACK2: begin
          if (bus.inta_n) begin
            state_d = ST_IDLE;
`ifdef PIC_AEOI_EN
            if (aeoi && real_q) isr_d[lvl_q] = 1'b0;
`endif
          end
        end
      endcase
    end

    int_out_d = (state_d == ST_REQ) || (state_d == ST_ACK1);
    oe_d      = (state_d == ST_ACK2);
    vec_d     = oe_d ? {vec_base, lvl_d} : '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      irq_q     <= '0;
      inta_q    <= 1'b1;
      irr_q     <= '0;
      isr_q     <= '0;
      cnt_q     <= '0;
      lvl_q     <= '0;
      real_q    <= 1'b0;
      int_out_q <= 1'b0;
      oe_q      <= 1'b0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq;
      inta_q    <= bus.inta_n;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      real_q    <= real_d;
      int_out_q <= int_out_d;
      oe_q      <= oe_d;
      vec_q     <= vec_d;
    end
  end

  assign bus.int_out    = int_out_q;
  assign bus.vector_out = vec_q;
  assign bus.vector_oe  = oe_q;
  assign irr            = irr_q;
  assign isr            = isr_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb_pic_inta_sequencer: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural reference model.
module tb_pic_inta_sequencer;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n, init_done, ltim;
  logic [4:0] vec_base;
  logic [7:0] imr, irq;
  logic       eoi_valid, eoi_specific;
  logic [2:0] eoi_level;
  logic [7:0] irr, isr;
`ifdef PIC_AEOI_EN
  logic       aeoi = 1'b0;
`endif

  pic_inta_sequencer_if bus ();

  pic_inta_sequencer #(.INTA_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_done    (init_done),
    .ltim         (ltim),
    .vec_base     (vec_base),
    .imr          (imr),
    .irq          (irq),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
`ifdef PIC_AEOI_EN
    .aeoi         (aeoi),
`endif
    .bus          (bus),
    .irr          (irr),
    .isr          (isr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 requesting, 2 first ack seen, 3 vector out.
  int         m_phase = 0, m_wait = 0, m_lvl = 0;
  bit         m_real = 1'b0;
  logic [7:0] m_irr = '0, m_isr = '0, m_prev_irq = '0;
  logic       m_prev_inta = 1'b1;
  logic       m_int = 1'b0, m_oe = 1'b0;
  logic [7:0] m_vec = '0;

  task automatic model_step();
    int         win, top;
    bit         fall;
    logic [7:0] nirr, nisr;
    if (!rst_n) begin
      m_phase = 0; m_wait = 0; m_irr = '0; m_isr = '0;
      m_prev_irq = '0; m_prev_inta = 1'b1;
      m_int = 1'b0; m_oe = 1'b0; m_vec = '0;
      return;
    end
    win = 8;
    top = 8;
    for (int i = 7; i >= 0; i--) begin
      if (m_irr[i] && !imr[i]) win = i;
      if (m_isr[i]) top = i;
    end
    if (win >= top) win = 8;
    fall = m_prev_inta && !bus.inta_n;
    nirr = ltim ? irq : (m_irr | (irq & ~m_prev_irq));
    nisr = m_isr;
    m_prev_irq  = irq;
    m_prev_inta = bus.inta_n;
    if (!init_done) begin
      m_phase = 0; m_irr = '0; m_isr = '0; m_wait = 0;
    end else begin
      if (eoi_valid) begin
        if (eoi_specific) nisr[eoi_level] = 1'b0;
        else if (top < 8) nisr[top] = 1'b0;
      end
      case (m_phase)
        0: if (win < 8) m_phase = 1;
        1: begin
          if (fall) begin
            m_phase = 2; m_wait = 0;
            m_real  = (win < 8);
            m_lvl   = m_real ? win : 7;
            if (m_real) begin nisr[win] = 1'b1; nirr[win] = 1'b0; end
          end else if (win == 8) m_phase = 0;
        end
        2: begin
          if (fall) m_phase = 3;
          else begin
            m_wait++;
            if (m_wait == TMO) begin
              m_phase = 0;
              if (m_real) nisr[m_lvl] = 1'b0;
            end
          end
        end
        default: if (bus.inta_n) m_phase = 0;
      endcase
      m_irr = nirr;
      m_isr = nisr;
    end
    m_int = (m_phase == 1) || (m_phase == 2);
    m_oe  = (m_phase == 3);
    m_vec = m_oe ? {vec_base, m_lvl[2:0]} : 8'h00;
  endtask

  // Advance the model on every edge and compare shortly afterwards.
  always @(posedge clk) begin
    model_step();
    #1;
    if (chk_en) begin
      check("model_int_out",    bus.int_out,    m_int);
      check("model_vector_oe",  bus.vector_oe,  m_oe);
      check("model_vector_out", bus.vector_out, m_vec);
      check("model_irr",        irr,            m_irr);
      check("model_isr",        isr,            m_isr);
    end
  end

  // Two INTA pulses starting at a negedge while int_out is high.
  task automatic do_ack(output logic [7:0] vec, output logic oe);
    bus.inta_n = 1'b0; @(negedge clk);
    bus.inta_n = 1'b1; @(negedge clk);
    bus.inta_n = 1'b0; @(negedge clk);
    vec = bus.vector_out;
    oe  = bus.vector_oe;
    bus.inta_n = 1'b1; @(negedge clk);
    check("oe_drop", bus.vector_oe, 1'b0);
  endtask

  task automatic wait_int(input string tag);
    int n = 0;
    while (bus.int_out !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.int_out, 1'b1);
  endtask

  task automatic send_eoi(input logic spec, input logic [2:0] lvl);
    eoi_valid = 1'b1; eoi_specific = spec; eoi_level = lvl;
    @(negedge clk);
    eoi_valid = 1'b0;
  endtask

  logic [7:0] v;
  logic       oe;

  initial begin
    rst_n = 1'b0; init_done = 1'b0; ltim = 1'b0; vec_base = 5'b01000;
    imr = '0; irq = '0; bus.inta_n = 1'b1;
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_int_out", bus.int_out, 1'b0);
    check("rst_vec_oe",  bus.vector_oe, 1'b0);
    check("rst_vec",     bus.vector_out, 8'h00);
    check("rst_irr",     irr, 8'h00);
    check("rst_isr",     isr, 8'h00);
    rst_n = 1'b1; init_done = 1'b1;
    @(negedge clk);

    // Basic edge-triggered acknowledge of IR3.
    irq = 8'h08; @(negedge clk);
    irq = 8'h00; @(negedge clk);
    check("int_req3", bus.int_out, 1'b1);
    check("irr_req3", irr, 8'h08);
    do_ack(v, oe);
    check("vec_ir3", v, 8'h43);
    check("oe_ir3", oe, 1'b1);
    check("isr_ir3", isr, 8'h08);
    check("irr_clr3", irr, 8'h00);

    // Lower priority blocked by in-service IR3; higher priority nests.
    irq = 8'h20; repeat (3) @(negedge clk);
    check("int_blocked5", bus.int_out, 1'b0);
    irq = 8'h22;
    wait_int("int_req1");
    do_ack(v, oe);
    check("vec_ir1", v, 8'h41);
    check("isr_nest", isr, 8'h0A);
    irq = 8'h00;

    // EOI handling, then build isr = 22 and retire it.
    send_eoi(1'b0, 3'd0);
    check("isr_nseoi", isr, 8'h08);
    send_eoi(1'b1, 3'd3);
    check("isr_seoi3", isr, 8'h00);
    wait_int("int_req5");
    do_ack(v, oe);
    check("vec_ir5", v, 8'h45);
    irq = 8'h02;
    wait_int("int_req1b");
    do_ack(v, oe);
    check("isr_22", isr, 8'h22);
    irq = 8'h00;
    send_eoi(1'b0, 3'd0);
    check("isr_nseoi22", isr, 8'h20);
    send_eoi(1'b1, 3'd5);
    check("isr_seoi5", isr, 8'h00);

    // Level-mode request withdrawn before the first INTA -> spurious IR7.
    ltim = 1'b1; irq = 8'h04;
    wait_int("int_lvl2");
    irq = 8'h00; @(negedge clk);
    check("int_still_req", bus.int_out, 1'b1);
    do_ack(v, oe);
    check("vec_spurious", v, 8'h47);
    check("oe_spurious", oe, 1'b1);
    check("isr_spurious", isr, 8'h00);

    // First INTA only: timeout restores isr, pending request re-asserts.
    ltim = 1'b0; irq = 8'h40;
    wait_int("int_req6");
    bus.inta_n = 1'b0; irq = 8'h00; @(negedge clk);
    check("isr_ack1_6", isr, 8'h40);
    bus.inta_n = 1'b1; irq = 8'h40;
    repeat (3) @(negedge clk);
    check("ack1_hold", bus.int_out, 1'b1);
    @(negedge clk);
    check("timeout_int", bus.int_out, 1'b0);
    check("timeout_isr", isr, 8'h00);
    @(negedge clk);
    check("reassert_int", bus.int_out, 1'b1);
    do_ack(v, oe);
    check("vec_ir6", v, 8'h46);
    irq = 8'h00;
    send_eoi(1'b0, 3'd0);
    check("isr_eoi6", isr, 8'h00);

    // init_done drop in the middle of a sequence.
    irq = 8'h01;
    wait_int("int_req0");
    bus.inta_n = 1'b0; @(negedge clk);
    bus.inta_n = 1'b1; init_done = 1'b0; @(negedge clk);
    check("init_isr", isr, 8'h00);
    check("init_irr", irr, 8'h00);
    check("init_int", bus.int_out, 1'b0);
    init_done = 1'b1; irq = 8'h00; @(negedge clk);

    // Masking the pending winner withdraws the request within a cycle.
    irq = 8'h10;
    wait_int("int_req4");
    imr = 8'h10; @(negedge clk);
    check("imr_drop", bus.int_out, 1'b0);
    imr = 8'h00; @(negedge clk);
    check("imr_restore", bus.int_out, 1'b1);
    do_ack(v, oe);
    check("vec_ir4", v, 8'h44);
    irq = 8'h00;
    send_eoi(1'b0, 3'd0);

    // Reset while the vector is on the bus.
    irq = 8'h01;
    wait_int("int_req0b");
    bus.inta_n = 1'b0; @(negedge clk);
    bus.inta_n = 1'b1; @(negedge clk);
    bus.inta_n = 1'b0; @(negedge clk);
    check("ack2_oe", bus.vector_oe, 1'b1);
    check("ack2_vec", bus.vector_out, 8'h40);
    rst_n = 1'b0; @(negedge clk);
    check("rst_ack2_oe", bus.vector_oe, 1'b0);
    check("rst_ack2_vec", bus.vector_out, 8'h00);
    check("rst_ack2_int", bus.int_out, 1'b0);
    check("rst_ack2_isr", isr, 8'h00);
    rst_n = 1'b1; bus.inta_n = 1'b1; irq = 8'h00; @(negedge clk);
    check("post_rst_oe", bus.vector_oe, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq[$urandom_range(0, 7)] = ~irq[$urandom_range(0, 7)];
      if ($urandom_range(0, 31) == 0) imr = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 199) == 0) ltim = ~ltim;
      if ($urandom_range(0, 99) == 0) vec_base = 5'($urandom);
      bus.inta_n   = ($urandom_range(0, 2) != 0);
      eoi_valid    = ($urandom_range(0, 15) == 0);
      eoi_specific = 1'($urandom);
      eoi_level    = 3'($urandom);
      init_done    = ($urandom_range(0, 149) != 0);
      rst_n        = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pic_inta_sequencer.md
PIC_INTA_SEQUENCER -- requirements
Module: pic_inta_sequencer

Interface
REQ-001 Parameter INTA_TIMEOUT, default 255: clk cycles to wait in ACK1 for the second INTA falling edge; range 1..255.
REQ-002 Signal clk, input, 1: the single clock; all logic is rising-edge clocked.
REQ-003 Signal rst_n, input, 1: synchronous, active-low reset.
REQ-004 Signal init_done, input, 1: initialization-word sequence complete.
REQ-005 Signal ltim, input, 1: trigger mode; 0 = edge, 1 = level.
REQ-006 Signal vec_base, input, 5: vector bits T7..T3 from ICW2.
REQ-007 Signal imr, input, 8: interrupt mask; 1 = masked.
REQ-008 Signal irq, input, 8: IR0..IR7 request lines, synchronous to clk.
REQ-009 Signal inta_n, input, 1: CPU acknowledge strobe, active-low, synchronous to clk.
REQ-010 Signal eoi_valid, input, 1: one-cycle end-of-interrupt command strobe (from OCW2).
REQ-011 Signal eoi_specific, input, 1: 1 = specific EOI, 0 = non-specific.
REQ-012 Signal eoi_level, input, 3: target level for a specific EOI.
REQ-013 Signal int_out, output, 1: interrupt request to the CPU.
REQ-014 Signal vector_out, output, 8: vector byte.
REQ-015 Signal vector_oe, output, 1: vector_out valid for the data bus.
REQ-016 Signal irr, output, 8: interrupt request register.
REQ-017 Signal isr, output, 8: in-service register.

Function
REQ-018 Priority SHALL be fully nested: IR0 highest, IR7 lowest.
REQ-019 Edge mode: irr[i] SHALL set on an irq[i] 0->1 transition between consecutive clk samples.
REQ-020 Level mode: irr[i] SHALL equal registered irq[i].
REQ-021 A winner SHALL be the highest-priority bit with irr=1 and imr=0 that has strictly higher priority than every set isr bit.
REQ-022 FSM states: IDLE, REQ, ACK1, ACK2.
REQ-023 IDLE->REQ when a winner exists; REQ->IDLE when the winner vanishes before the first INTA.
REQ-024 In REQ and ACK1, int_out SHALL be 1; int_out SHALL be 0 in all other states.
REQ-025 First inta_n falling edge (1->0 across consecutive samples) in REQ -> ACK1, registered one cycle later.
REQ-026 On entry to ACK1 the current winner SHALL be frozen, its isr bit set and its irr bit cleared.
REQ-027 Spurious case, no winner at the first INTA: freeze level 7, set no isr bit, clear no irr bit.
REQ-028 Second inta_n falling edge in ACK1 -> ACK2.
REQ-029 In ACK2, vector_out = {vec_base, frozen level} and vector_oe = 1 while inta_n = 0.
REQ-030 ACK2 -> IDLE on the inta_n rise; vector_oe SHALL drop in that same cycle.
REQ-031 ACK1 timeout: INTA_TIMEOUT cycles without a second edge -> IDLE, clearing the isr bit set at ACK1.
REQ-032 Non-specific EOI SHALL clear the highest-priority set isr bit; no effect when isr = 0.
REQ-033 Specific EOI SHALL clear isr[eoi_level].
REQ-034 Same-cycle EOI clear and ACK1 set on the same bit: the set SHALL win.
REQ-035 Same-cycle EOI clear and ACK1 set on different bits: both SHALL apply.
REQ-036 Same-cycle irr set and ACK1 clear on the winning bit: the clear SHALL win.
REQ-037 init_done = 0 SHALL force IDLE, irr = 0, isr = 0 and ignore inta_n and EOI, including mid-sequence.
REQ-038 imr changes SHALL affect winner selection within one cycle, but not an already-frozen level.

Reset
REQ-039 When rst_n = 0 at a clk edge: state = IDLE, irr = 0, isr = 0, int_out = 0, vector_out = 0, vector_oe = 0, timeout counter = 0, irq/inta_n sample registers = 0/1.
REQ-040 Reset SHALL abort any INTA sequence in progress, with no vector driven afterwards.

Configuration
REQ-041 With PIC_AEOI_EN defined, an aeoi input port SHALL exist; when aeoi = 1, the frozen isr bit SHALL clear on the ACK2->IDLE transition.
REQ-042 Without PIC_AEOI_EN, no aeoi port SHALL exist and isr SHALL be cleared only by EOI, timeout, reset or init_done = 0.

Structure
REQ-043 Package pic_pkg SHALL hold the FSM state enum, NUM_IR = 8, LEVEL_W = 3, and the spurious level constant 7.
REQ-044 Sub-module pic_priority_resolver (combinational find-first over irr & ~imr, gated by isr) SHALL be instantiated once.
REQ-045 The same resolver logic SHALL serve non-specific EOI selection over isr.

Verification
REQ-046 Edge mode, imr = 0, vec_base = 5'b01000, pulse irq[3] -> int_out = 1; two INTA pulses -> isr = 8'h08, irr[3] = 0, vector_out = 8'h43 with vector_oe during the second pulse.
REQ-047 isr = 8'h08, raise irq[5] -> int_out stays 0; raise irq[1] -> int_out = 1, and the ack gives isr = 8'h0A and vector 8'h41.
REQ-048 Raise irq[2] in level mode, drop it before the first INTA -> vector 8'h47 (with vec_base 5'b01000), isr unchanged.
REQ-049 isr = 8'h22, non-specific EOI -> isr = 8'h20; specific EOI level 5 -> isr = 8'h00.
REQ-050 First INTA only, INTA_TIMEOUT = 4 -> IDLE after 4 cycles, isr restored, int_out re-asserted if irr is still pending.
REQ-051 rst_n = 0 during ACK2 -> vector_oe = 0 and all outputs at reset values on the next clk.
